// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - per-level dynamite sequencer: drop, fuse, blast and hit detection
//
// Ports:
//   clk          system/pixel clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-clk pulse per video frame
//   level_start  one-clk pulse: reload bomb stock, abort any bomb
//   active       level live; low forces IDLE without touching stock
//   bomb_key     raw drop button, asynchronous to clk
//   char_pos_x/y character centre
//   bomb_pos_x/y latched bomb centre
//   b_cnt        0 idle, 1/2 fuse, 3 blast
//   bombs_left   remaining stock
//   blast        one-clk pulse when b_cnt first reads 3
//   char_hit     one-clk pulse, at most once per bomb
module bomb_controller #(
  parameter int FUSE_FRAMES  = 30,
  parameter int BLAST_FRAMES = 15,
  parameter int BLAST_RADIUS = 40,
  parameter int BOMB_Y_OFS   = 18,
  parameter int BOMB_STOCK   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       level_start,
  input  logic       active,
  input  logic       bomb_key,
  input  logic [9:0] char_pos_x,
  input  logic [9:0] char_pos_y,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic [3:0] b_cnt,
  output logic [3:0] bombs_left,
  output logic       blast,
  output logic       char_hit
);

  localparam int CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE1 = 2'd1,
    S_FUSE2 = 2'd2,
    S_BLAST = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          key_s1, key_s2, key_prev;
  logic          key_rise;
  logic          drop;
  logic          abort;
  logic          blast_next, hit_next;
  logic          hit_done;
  logic [9:0]    clamp_x, clamp_y;
  logic [10:0]   sum_y;
  logic [9:0]    dx, dy;

  assign key_rise = key_s2 & ~key_prev;
  assign abort    = level_start | ~active;
  assign b_cnt    = {2'b00, state};

  // Drop position: x kept fully on screen, y moved to feet level and saturated.
  assign sum_y   = {1'b0, char_pos_y} + 11'(BOMB_Y_OFS);
  assign clamp_x = (char_pos_x < 10'd10)  ? 10'd10  :
                   (char_pos_x > 10'd629) ? 10'd629 : char_pos_x;
  assign clamp_y = (sum_y > 11'd469) ? 10'd469 : sum_y[9:0];

  assign dx = (char_pos_x >= bomb_pos_x) ? (char_pos_x - bomb_pos_x) : (bomb_pos_x - char_pos_x);
  assign dy = (char_pos_y >= bomb_pos_y) ? (char_pos_y - bomb_pos_y) : (bomb_pos_y - char_pos_y);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    drop       = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The clearing of cnt here also discards a coincident frame_tick.
          if (key_rise && bombs_left != 4'd0) begin
            state_next = S_FUSE1;
            cnt_next   = '0;
            drop       = 1'b1;
          end
        end
        S_FUSE1, S_FUSE2: begin
          if (frame_tick) begin
            if (cnt == CW'(FUSE_FRAMES - 1)) begin
              state_next = (state == S_FUSE1) ? S_FUSE2 : S_BLAST;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        default: begin
          if (frame_tick) begin
            if (cnt == CW'(BLAST_FRAMES - 1)) begin
              state_next = S_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    blast_next = 1'b0;
    hit_next   = 1'b0;
    if (!abort) begin
      blast_next = (state == S_FUSE2) && (state_next == S_BLAST);
      hit_next   = (state == S_BLAST) && !hit_done &&
                   (dx <= 10'(BLAST_RADIUS)) && (dy <= 10'(BLAST_RADIUS));
    end
  end

  // Synchronizer, stock, position latch and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1     <= 1'b0;
      key_s2     <= 1'b0;
      key_prev   <= 1'b0;
      bomb_pos_x <= '0;
      bomb_pos_y <= '0;
      bombs_left <= 4'(BOMB_STOCK);
      blast      <= 1'b0;
      char_hit   <= 1'b0;
      hit_done   <= 1'b0;
    end else begin
      key_s1   <= bomb_key;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      blast    <= blast_next;
      char_hit <= hit_next;
      if (level_start) begin
        bombs_left <= 4'(BOMB_STOCK);
      end else if (drop) begin
        bombs_left <= bombs_left - 4'd1;
      end
      if (drop) begin
        bomb_pos_x <= clamp_x;
        bomb_pos_y <= clamp_y;
        hit_done   <= 1'b0;
      end else if (hit_next) begin
        hit_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// tb/tb_bomb_controller.sv - scoreboard bench for bomb_controller
module tb_bomb_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       level_start = 1'b0;
  logic       active = 1'b1;
  logic       bomb_key = 1'b0;
  logic [9:0] char_pos_x = '0;
  logic [9:0] char_pos_y = '0;
  logic [9:0] bomb_pos_x, bomb_pos_y;
  logic [3:0] b_cnt, bombs_left;
  logic       blast, char_hit;

  bomb_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .level_start(level_start),
    .active(active), .bomb_key(bomb_key), .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .bomb_pos_x(bomb_pos_x), .bomb_pos_y(bomb_pos_y), .b_cnt(b_cnt),
    .bombs_left(bombs_left), .blast(blast), .char_hit(char_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int hit_count = 0;
  int blast_count = 0;
  int model_bombs = 6;

  always @(posedge clk) begin
    if (char_hit) hit_count <= hit_count + 1;
    if (blast)    blast_count <= blast_count + 1;
  end

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  function automatic int exp_x(input int x);
    if (x < 10) return 10;
    if (x > 629) return 629;
    return x;
  endfunction

  function automatic int exp_y(input int y);
    if (y + 18 > 469) return 469;
    return y + 18;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      step();
    end
  endtask

  task automatic wait_bcnt(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (int'(b_cnt) == target) break;
      step();
    end
  endtask

  task automatic level_pulse();
    level_start = 1'b1;
    step();
    level_start = 1'b0;
    model_bombs = 6;
  endtask

  task automatic drop_bomb(input int x, input int y, input int hold);
    char_pos_x = 10'(x);
    char_pos_y = 10'(y);
    sb_push("drop_pos_x", exp_x(x));
    sb_push("drop_pos_y", exp_y(y));
    sb_push("drop_b_cnt", 1);
    model_bombs = model_bombs - 1;
    sb_push("drop_bombs_left", model_bombs);
    bomb_key = 1'b1;
    wait_bcnt(1, 10);
    sb_pop(bomb_pos_x);
    sb_pop(bomb_pos_y);
    sb_pop(b_cnt);
    sb_pop(bombs_left);
    repeat (hold) step();
    bomb_key = 1'b0;
    repeat (4) step();
  endtask

  int b0, h0;

  initial begin
    // Reset state
    repeat (3) step();
    sb_push("rst_pos_x", 0);  sb_push("rst_pos_y", 0);  sb_push("rst_b_cnt", 0);
    sb_push("rst_bombs", 6);  sb_push("rst_blast", 0);  sb_push("rst_hit", 0);
    sb_pop(bomb_pos_x); sb_pop(bomb_pos_y); sb_pop(b_cnt);
    sb_pop(bombs_left); sb_pop(blast); sb_pop(char_hit);
    rst_n = 1'b1;
    step();

    // Basic drop, key held 200 clks, full fuse/blast cycle
    b0 = blast_count;
    drop_bomb(100, 200, 200);
    sb_push("held_b_cnt", 1); sb_push("held_bombs", 5);
    sb_pop(b_cnt); sb_pop(bombs_left);
    sb_push("tick29_b_cnt", 1); run_ticks(29); sb_pop(b_cnt);
    sb_push("tick30_b_cnt", 2); run_ticks(1);  sb_pop(b_cnt);
    sb_push("tick59_b_cnt", 2); run_ticks(29); sb_pop(b_cnt);
    sb_push("tick60_b_cnt", 3); sb_push("tick60_blast", 1);
    pulse_tick();
    sb_pop(b_cnt); sb_pop(blast);
    sb_push("blast_after", 0); step(); sb_pop(blast);
    sb_push("tick75_b_cnt", 0); run_ticks(15); sb_pop(b_cnt);
    sb_push("one_blast", 1); sb_pop(blast_count - b0);
    sb_push("one_drop", 5); sb_pop(bombs_left);

    // Asynchronous reset in FUSE2
    drop_bomb(150, 150, 0);
    run_ticks(40);
    sb_push("pre_rst_b_cnt", 2); sb_pop(b_cnt);
    rst_n = 1'b0;
    #2;
    sb_push("arst_b_cnt", 0); sb_push("arst_bombs", 6); sb_push("arst_blast", 0);
    sb_pop(b_cnt); sb_pop(bombs_left); sb_pop(blast);
    step();
    rst_n = 1'b1;
    model_bombs = 6;
    step();

    // Clamp corners
    drop_bomb(5, 470, 0);
    sb_push("clamp1_idle", 0); run_ticks(75); sb_pop(b_cnt);
    drop_bomb(635, 100, 0);
    sb_push("clamp2_idle", 0); run_ticks(75); sb_pop(b_cnt);

    // Hit test at bomb (300,300)
    drop_bomb(300, 282, 0);
    char_pos_x = 10'd341;
    char_pos_y = 10'd300;
    run_ticks(59);
    h0 = hit_count;
    sb_push("hit_blast_b_cnt", 3); pulse_tick(); sb_pop(b_cnt);
    repeat (4) step();
    sb_push("miss_341", 0); sb_pop(hit_count - h0);
    char_pos_x = 10'd340;
    char_pos_y = 10'd260;
    repeat (4) step();
    sb_push("hit_340_260", 1); sb_pop(hit_count - h0);
    char_pos_x = 10'd600;
    char_pos_y = 10'd50;
    repeat (2) step();
    char_pos_x = 10'd320;
    char_pos_y = 10'd300;
    repeat (4) step();
    sb_push("no_second_hit", 1); sb_pop(hit_count - h0);
    sb_push("hit_idle", 0); run_ticks(15); sb_pop(b_cnt);

    // Stock exhaustion and reload
    level_pulse();
    sb_push("reload_bombs", 6); sb_pop(bombs_left);
    for (int i = 0; i < 6; i++) begin
      drop_bomb(200, 200, 0);
      run_ticks(75);
    end
    sb_push("empty_bombs", 0); sb_push("empty_b_cnt", 0);
    sb_pop(bombs_left); sb_pop(b_cnt);
    bomb_key = 1'b1;
    repeat (6) step();
    sb_push("seventh_b_cnt", 0); sb_push("seventh_bombs", 0);
    sb_pop(b_cnt); sb_pop(bombs_left);
    bomb_key = 1'b0;
    repeat (3) step();
    level_pulse();
    sb_push("restock_bombs", 6); sb_pop(bombs_left);

    // key_rise coincident with level_start
    bomb_key = 1'b1;
    step();
    step();
    level_start = 1'b1;
    step();
    level_start = 1'b0;
    sb_push("ls_key_b_cnt", 0); sb_push("ls_key_bombs", 6);
    sb_pop(b_cnt); sb_pop(bombs_left);
    repeat (3) step();
    bomb_key = 1'b0;
    repeat (3) step();

    // key_rise during FUSE1 ignored
    drop_bomb(250, 250, 0);
    bomb_key = 1'b1;
    repeat (6) step();
    sb_push("fuse1_key_b_cnt", 1); sb_push("fuse1_key_bombs", 5);
    sb_pop(b_cnt); sb_pop(bombs_left);
    bomb_key = 1'b0;
    repeat (3) step();

    // active=0 during BLAST
    run_ticks(59);
    sb_push("inact_pre_b_cnt", 3); pulse_tick(); sb_pop(b_cnt);
    step();
    active = 1'b0;
    step();
    sb_push("inact_b_cnt", 0); sb_push("inact_bombs", 5);
    sb_pop(b_cnt); sb_pop(bombs_left);
    active = 1'b1;
    step();

    if (sb_q.size() != 0) check("scoreboard_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
